// File: rtl/viterbi_ber_monitor_pkg.sv
// viterbi_ber_monitor_pkg: shared types and helpers for the Viterbi BER monitor.
package viterbi_ber_monitor_pkg;

    // Default width of the statistics counters
    localparam int CNT_W = 16;

    // Monitor FSM: hunting for the decoder latency, or measuring at it
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Number of set bits in a 2-bit symbol difference (0..2)
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage

// File: rtl/viterbi_ber_monitor_sat_counter.sv
// ber_sat_counter: W-bit accumulator adding 0..3 per enabled cycle, sticking
// at all-ones instead of wrapping.
module ber_sat_counter
    import viterbi_ber_monitor_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    // One extra carry bit tells us the add would overflow; clamp in that case
    always_comb begin
        sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc_i};
        cnt_d = cnt_q;
        if (en_i) cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/viterbi_ber_monitor.sv
// viterbi_ber_monitor: finds the decoder latency against a delay line of the
// encoder input, locks on it and accumulates symbol / bit-error statistics.
// Optional feature macro: VITERBI_BER_MON_FLAGS_EN (honour Error as erasure,
// build the FlagCnt counter).
module viterbi_ber_monitor
    import viterbi_ber_monitor_pkg::state_e, viterbi_ber_monitor_pkg::SEARCH,
           viterbi_ber_monitor_pkg::LOCKED, viterbi_ber_monitor_pkg::popcount2;
#(
    parameter  int DEPTH    = 16,
    parameter  int WIN      = 8,
    parameter  int LOSS_THR = 4,
    parameter  int CNT_W    = viterbi_ber_monitor_pkg::CNT_W,
    localparam int LAT_W    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic [1:0]       X,
    input  logic [2:0]       Out,
    input  logic             Error,
    output logic             Locked,
    output logic [LAT_W-1:0] Lat,
    output logic [CNT_W-1:0] SymCnt,
    output logic [CNT_W-1:0] BitErrs,
    output logic             Mismatch,
    output logic [CNT_W-1:0] FlagCnt
);

    localparam int FILL_W  = $clog2(DEPTH + 1);
    localparam int RUN_MAX = (WIN > LOSS_THR) ? WIN : LOSS_THR;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    state_e                  state_q, state_d;
    logic [DEPTH-2:0][1:0]   dline_q;
    logic [DEPTH-1:0][1:0]   taps;
    logic [FILL_W-1:0]       fill_q;
    logic [LAT_W-1:0]        lat_q, lat_d, lat_nxt;
    logic [RUN_W-1:0]        run_q, run_d;
    logic                    mis_q, mis_d;
    logic                    valid, erase, hit;
    logic [1:0]              diff;
    logic                    sym_en, bit_en, flag_en;

    // Tap 0 is the live input, so candidate latency 0 needs no register
    assign taps    = {dline_q, X};
    assign valid   = fill_q > FILL_W'(lat_q);
    assign diff    = Out[1:0] ^ taps[lat_q];
    assign hit     = (diff == 2'b00);
    assign lat_nxt = (lat_q == LAT_W'(DEPTH - 1)) ? '0 : lat_q + 1'b1;

`ifdef VITERBI_BER_MON_FLAGS_EN
    assign erase = Error;
    logic unused_in;
    assign unused_in = Out[2];
`else
    assign erase = 1'b0;
    logic unused_in;
    assign unused_in = ^{Out[2], Error, flag_en};
`endif

    // Delay line of past X values and a saturating count of samples taken
    always_ff @(posedge Clk) begin
        if (Res) begin
            dline_q <= '0;
            fill_q  <= '0;
        end else begin
            dline_q <= taps[DEPTH-2:0];
            if (fill_q != FILL_W'(DEPTH)) fill_q <= fill_q + 1'b1;
        end
    end

    // FSM state, latency candidate, run counter and mismatch pulse registers
    always_ff @(posedge Clk) begin
        if (Res) begin
            state_q <= SEARCH;
            lat_q   <= '0;
            run_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            run_q   <= run_d;
            mis_q   <= mis_d;
        end
    end

    // Next state: run counts matches while searching, mismatches while locked
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        run_d   = run_q;
        if (valid) begin
            if (state_q == SEARCH) begin
                if (erase || !hit) begin
                    run_d = '0;
                    lat_d = lat_nxt;
                end else if (run_q == RUN_W'(WIN - 1)) begin
                    state_d = LOCKED;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end else if (!erase) begin
                if (hit) begin
                    run_d = '0;
                end else if (run_q == RUN_W'(LOSS_THR - 1)) begin
                    state_d = SEARCH;
                    lat_d   = lat_nxt;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
        end
    end

    // Outputs: statistics only move while locked; erasures skip comparison
    always_comb begin
        Locked  = (state_q == LOCKED);
        sym_en  = 1'b0;
        bit_en  = 1'b0;
        flag_en = 1'b0;
        mis_d   = 1'b0;
        if (valid && state_q == LOCKED) begin
            if (erase) begin
                flag_en = 1'b1;
            end else begin
                sym_en = 1'b1;
                bit_en = !hit;
                mis_d  = !hit;
            end
        end
    end

    assign Lat      = lat_q;
    assign Mismatch = mis_q;

    ber_sat_counter #(.W(CNT_W)) u_sym_cnt (
        .clk_i (Clk), .rst_i (Res), .en_i (sym_en), .inc_i (2'd1), .cnt_o (SymCnt)
    );

    ber_sat_counter #(.W(CNT_W)) u_bit_errs (
        .clk_i (Clk), .rst_i (Res), .en_i (bit_en), .inc_i (popcount2(diff)), .cnt_o (BitErrs)
    );

`ifdef VITERBI_BER_MON_FLAGS_EN
    ber_sat_counter #(.W(CNT_W)) u_flag_cnt (
        .clk_i (Clk), .rst_i (Res), .en_i (flag_en), .inc_i (2'd1), .cnt_o (FlagCnt)
    );
`else
    assign FlagCnt = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// tb_viterbi_ber_monitor: directed scenarios against a queue-based reference
// model; a 16-bit and a 4-bit counter instance share the same stimulus.
module tb_viterbi_ber_monitor;

    localparam int DEPTH = 16, WIN = 8, LOSS_THR = 4, CW = 16, CWS = 4;
`ifdef VITERBI_BER_MON_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       Clk = 1'b0, Res = 1'b1, Error = 1'b0;
    logic [1:0] X = 2'd0;
    logic [2:0] Out = 3'd0;

    logic          Locked, Mismatch, Locked_s, Mismatch_s;
    logic [3:0]    Lat, Lat_s;
    logic [CW-1:0] SymCnt, BitErrs, FlagCnt;
    logic [CWS-1:0] SymCnt_s, BitErrs_s, FlagCnt_s;

    always #5 Clk = ~Clk;

    viterbi_ber_monitor #(.DEPTH(DEPTH), .WIN(WIN), .LOSS_THR(LOSS_THR), .CNT_W(CW)) dut (
        .Clk(Clk), .Res(Res), .X(X), .Out(Out), .Error(Error),
        .Locked(Locked), .Lat(Lat), .SymCnt(SymCnt), .BitErrs(BitErrs),
        .Mismatch(Mismatch), .FlagCnt(FlagCnt)
    );

    viterbi_ber_monitor #(.DEPTH(DEPTH), .WIN(WIN), .LOSS_THR(LOSS_THR), .CNT_W(CWS)) dut_s (
        .Clk(Clk), .Res(Res), .X(X), .Out(Out), .Error(Error),
        .Locked(Locked_s), .Lat(Lat_s), .SymCnt(SymCnt_s), .BitErrs(BitErrs_s),
        .Mismatch(Mismatch_s), .FlagCnt(FlagCnt_s)
    );

    int checks = 0, passed = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- reference model ----------------
    logic [1:0] hist[$];          // hist[k] = X from k+1 cycles ago
    int  m_lat, m_run, m_nsamp, m_nerr;
    int  m_sym, m_bit, m_flag, s_sym, s_bit, s_flag;
    bit  m_locked, m_mis, m_erase;
    logic [1:0] m_refx, m_d;

    always @(posedge Clk) begin
        if (Res) begin
            m_lat = 0; m_run = 0; m_nsamp = 0; m_locked = 0; m_mis = 0;
            m_sym = 0; m_bit = 0; m_flag = 0; s_sym = 0; s_bit = 0; s_flag = 0;
            hist.delete();
        end else begin
            m_mis   = 0;
            m_erase = FLAGS && Error;
            if (m_nsamp > m_lat) begin
                m_refx = (m_lat == 0) ? X : hist[m_lat-1];
                m_d    = Out[1:0] ^ m_refx;
                m_nerr = int'(m_d[0]) + int'(m_d[1]);
                if (!m_locked) begin
                    if (m_erase || m_nerr != 0) begin
                        m_run = 0; m_lat = (m_lat + 1) % DEPTH;
                    end else begin
                        m_run++;
                        if (m_run == WIN) begin m_locked = 1; m_run = 0; end
                    end
                end else if (m_erase) begin
                    m_flag = sat(m_flag + 1, CW); s_flag = sat(s_flag + 1, CWS);
                end else begin
                    m_sym = sat(m_sym + 1, CW); s_sym = sat(s_sym + 1, CWS);
                    if (m_nerr == 0) m_run = 0;
                    else begin
                        m_bit = sat(m_bit + m_nerr, CW); s_bit = sat(s_bit + m_nerr, CWS);
                        m_mis = 1; m_run++;
                        if (m_run == LOSS_THR) begin
                            m_locked = 0; m_run = 0; m_lat = (m_lat + 1) % DEPTH;
                        end
                    end
                end
            end
            hist.push_front(X);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            if (m_nsamp < DEPTH) m_nsamp++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("Locked",     Locked,     m_locked);
            chk("Lat",        Lat,        m_lat);
            chk("SymCnt",     SymCnt,     m_sym);
            chk("BitErrs",    BitErrs,    m_bit);
            chk("Mismatch",   Mismatch,   m_mis);
            chk("FlagCnt",    FlagCnt,    m_flag);
            chk("Locked_s",   Locked_s,   m_locked);
            chk("Lat_s",      Lat_s,      m_lat);
            chk("SymCnt_s",   SymCnt_s,   s_sym);
            chk("BitErrs_s",  BitErrs_s,  s_bit);
            chk("Mismatch_s", Mismatch_s, m_mis);
            chk("FlagCnt_s",  FlagCnt_s,  s_flag);
        end
    end

    // ---------------- stimulus: decoder = 5-cycle delay of X ----------------
    logic [1:0]  xh[0:4];
    logic [1:0]  cnt_x = 2'd3;
    logic [31:0] rs = 32'h1234_5678;
    bit          rnd_mode = 1'b0;

    task automatic drive(input logic [1:0] mask, input bit err, input bit rst, input bit zero_x);
        logic [1:0] xn;
        @(negedge Clk);
        if (zero_x) xn = 2'd0;
        else if (rnd_mode) begin
            rs ^= rs << 13; rs ^= rs >> 17; rs ^= rs << 5;
            xn = rs[17:16];
        end else begin
            xn = cnt_x; cnt_x = cnt_x + 2'd1;
        end
        X     = xn;
        Out   = {1'b0, xh[4] ^ mask};
        Error = err;
        Res   = rst;
        for (int k = 4; k > 0; k--) xh[k] = xh[k-1];
        xh[0] = xn;
        @(posedge Clk); #1;
    endtask

    initial begin
        int n, sym_base;
        bit saw_wrap;
        logic [3:0] prev_lat;
        for (int k = 0; k < 5; k++) xh[k] = 2'd0;

        // reset
        drive(2'd0, 1'b0, 1'b1, 1'b1);
        cmp_en = 1'b1;
        drive(2'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_locked", Locked, 0);
        chk("rst_lat", Lat, 0);
        chk("rst_symcnt", SymCnt, 0);
        chk("rst_mismatch", Mismatch, 0);

        // initial lock on counter stimulus starting at 3
        n = 0;
        while (n < 5 + WIN + 8 && !Locked) begin drive(2'd0, 1'b0, 1'b0, 1'b0); n++; end
        chk("lock1_locked", Locked, 1);
        chk("lock1_lat", Lat, 5);
        chk("lock1_cycles", n, 15);

        // 100 clean locked symbols
        for (int i = 0; i < 100; i++) drive(2'd0, 1'b0, 1'b0, 1'b0);
        chk("clean_symcnt", SymCnt, 100);
        chk("clean_biterrs", BitErrs, 0);
        chk("clean_symcnt_s", SymCnt_s, 15);

        // single- and double-bit errors
        rnd_mode = 1'b1;
        for (int i = 0; i < 10; i++) drive(2'd0, 1'b0, 1'b0, 1'b0);
        chk("rnd_symcnt", SymCnt, 110);
        drive(2'd1, 1'b0, 1'b0, 1'b0);
        chk("err1_mismatch", Mismatch, 1);
        chk("err1_biterrs", BitErrs, 1);
        drive(2'd3, 1'b0, 1'b0, 1'b0);
        chk("err2_mismatch", Mismatch, 1);
        chk("err2_biterrs", BitErrs, 3);
        chk("err2_locked", Locked, 1);
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        chk("err_pulse_end", Mismatch, 0);
        chk("err_symcnt", SymCnt, 113);

        // erasures
        for (int i = 0; i < 3; i++) drive(2'd0, 1'b1, 1'b0, 1'b0);
        sym_base = FLAGS ? 113 : 116;
        chk("flag_flagcnt", FlagCnt, FLAGS ? 3 : 0);
        chk("flag_symcnt", SymCnt, sym_base);

        // push the 4-bit BitErrs past saturation without losing lock
        for (int i = 0; i < 10; i++) begin
            drive(2'd3, 1'b0, 1'b0, 1'b0);
            drive(2'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_biterrs", BitErrs, 23);
        chk("sat_biterrs_s", BitErrs_s, 15);
        chk("sat_locked", Locked, 1);

        // loss of lock after LOSS_THR consecutive mismatches
        for (int i = 0; i < 3; i++) drive(2'd1, 1'b0, 1'b0, 1'b0);
        chk("loss3_locked", Locked, 1);
        drive(2'd1, 1'b0, 1'b0, 1'b0);
        chk("loss4_locked", Locked, 0);
        chk("loss4_lat", Lat, 6);
        chk("loss4_biterrs", BitErrs, 27);

        // search wraps 15 -> 0 and relocks at 5, statistics kept
        n = 0; saw_wrap = 1'b0; prev_lat = Lat;
        while (n < 200 && !Locked) begin
            drive(2'd0, 1'b0, 1'b0, 1'b0);
            if (prev_lat == 4'd15 && Lat == 4'd0) saw_wrap = 1'b1;
            prev_lat = Lat; n++;
        end
        chk("relock_locked", Locked, 1);
        chk("relock_lat", Lat, 5);
        chk("relock_wrap", saw_wrap, 1);
        chk("relock_symcnt", SymCnt, sym_base + 24);
        chk("relock_biterrs", BitErrs, 27);

        // one-cycle reset while locked
        for (int i = 0; i < 5; i++) drive(2'd0, 1'b0, 1'b0, 1'b0);
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        chk("mrst_locked", Locked, 0);
        chk("mrst_lat", Lat, 0);
        chk("mrst_symcnt", SymCnt, 0);
        chk("mrst_biterrs", BitErrs, 0);
        chk("mrst_flagcnt", FlagCnt, 0);
        chk("mrst_mismatch", Mismatch, 0);
        n = 0;
        while (n < 100 && !Locked) begin drive(2'd0, 1'b0, 1'b0, 1'b0); n++; end
        chk("mrst_relock", Locked, 1);
        chk("mrst_relock_lat", Lat, 5);
        for (int i = 0; i < 20; i++) drive(2'd0, 1'b0, 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_monitor.md
# viterbi_ber_monitor

Downstream checker for the Viterbi chain: it sits after `viterbi` and compares the decoded symbol `Out` with the 2-bit encoder input `X`. It finds the decoder's unknown pipeline latency by searching over a bounded delay line and locks on it. While locked, it counts symbols and bit errors, and it drops lock after sustained mismatch. It gives the team a self-checking BER measurement in simulation and in hardware.

## Interface
Parameters:
- `DEPTH`, 16: delay-line length; latency candidates 0..DEPTH-1 cycles.
- `WIN`, 8: consecutive matching symbols required to declare lock.
- `LOSS_THR`, 4: consecutive mismatching symbols that force loss of lock.
- `CNT_W`, 16: width of all statistics counters.

Ports:
- `Clk  in  1`: single clock, rising edge.
- `Res  in  1`: synchronous, active-high reset.
- `X  in  2`: reference encoder input, sampled every cycle.
- `Out  in  3`: decoder output; `Out[1:0]` is compared, `Out[2]` is ignored.
- `Error  in  1`: decoder error flag; marks the current decoded symbol as an erasure.
- `Locked  out  1`: latency found; statistics are accumulating.
- `Lat  out  log2(DEPTH)`: current or locked latency candidate.
- `SymCnt  out  CNT_W`: symbols compared while locked (erasures excluded).
- `BitErrs  out  CNT_W`: bit errors while locked (popcount of the mismatch, 0..2 per symbol).
- `Mismatch  out  1`: one-cycle pulse on each locked, non-erased symbol mismatch.
- `FlagCnt  out  CNT_W`: count of erased symbols while locked (see Configuration).

## Operation
- Delay line: shift register of `DEPTH` 2-bit entries. `X` enters at tap 0 every cycle. Tap L holds `X` from L cycles earlier.
- Fill counter: saturates at `DEPTH`. Candidate L is only evaluated once more than L samples have been taken since reset.
- Per-cycle comparison: `d = Out[1:0] ^ tap[Lat]`. A symbol matches when `d == 0`.
- FSM states:
  - SEARCH:
    - Run counter `run` counts consecutive matches at `Lat`.
    - On a mismatch or `Error`: clear `run`, then `Lat <= Lat+1`, wrapping from DEPTH-1 to 0.
    - When `run` reaches `WIN`: go to LOCKED and clear `run`.
  - LOCKED:
    - `Error`=1: no comparison; increment `FlagCnt`; `run` unchanged.
    - Match: increment `SymCnt`; clear `run`.
    - Mismatch: increment `SymCnt`; add popcount(d) to `BitErrs`; pulse `Mismatch`; increment `run`.
    - When `run` reaches `LOSS_THR`: go to SEARCH with `Lat <= Lat+1` (wrapping) and `run` cleared. Statistics counters are kept.
- All counters saturate at all-ones and never wrap. `BitErrs` saturates even if +2 would overflow.
- `Lat` is held while LOCKED.

## Timing
- All outputs are registered and update on the rising `Clk` following the compared sample.
- Lock latency: `Locked` rises on the edge after the WIN-th consecutive match. Minimum is `WIN`+L+1 cycles after reset release.
- `Mismatch` is high for exactly one cycle per mismatching symbol. Back-to-back mismatches give a continuous high.
- Reset values: state SEARCH, `Lat`=0, `run`=0, fill=0, delay line all 0, `Locked`=0, `Mismatch`=0, `SymCnt`=`BitErrs`=`FlagCnt`=0.
- `Res` dominates every simultaneous event. Reset mid-lock clears the statistics and restarts the search at L=0.
- Wrap-around: from `Lat`=DEPTH-1, a search step goes to 0.

## Configuration
- `VITERBI_BER_MON_FLAGS_EN`
  - Defined: the `Error` input is honoured as an erasure, and `FlagCnt` counts erasures as described above.
  - Undefined: `Error` is ignored and every symbol is compared. `FlagCnt` is tied to 0 and its counter logic is not built.

## Structure
- Shared package holds:
  - the FSM state encoding (SEARCH=1'b0, LOCKED=1'b1);
  - a 2-bit popcount function;
  - the saturating-increment width constant `CNT_W`.
- One sub-module: `ber_sat_counter`, a CNT_W-wide saturating accumulator with a 2-bit increment. It is instantiated three times: `SymCnt`, `BitErrs`, `FlagCnt`.

## Test plan
- Model the decoder as a 5-cycle delay of `X` (counter stimulus starting at 3), with `Out[2]`=0.
  - Required: `Lat`=5 and `Locked`=1 by cycle 5+`WIN`+small search overhead.
  - Required: after 100 locked cycles, `SymCnt`=100 and `BitErrs`=0.
- While locked at L=5, invert `Out[0]` for one cycle.
  - Required: one `Mismatch` pulse and `BitErrs`+1.
  - Invert both bits on the next symbol instead: `BitErrs`+2. `Locked` stays 1.
- Corrupt 4 consecutive symbols (`LOSS_THR`=4).
  - Required: `Locked` falls on the 4th and `Lat`=6.
  - Search then wraps through 15→0 and relocks at 5. Counters are kept.
- With `VITERBI_BER_MON_FLAGS_EN` defined, hold `Error`=1 for 3 locked cycles.
  - Required: `FlagCnt`=3 and `SymCnt` unchanged.
  - Without the macro: `FlagCnt`=0 and the symbols are compared.
- Preload the counters near all-ones by forcing mismatches with `CNT_W`=4.
  - Required: `BitErrs` sticks at 15 and never wraps.
- Assert `Res` for one cycle while locked.
  - Required: all outputs return to their reset values on the next edge, and the search restarts at `Lat`=0.
